// File: rtl/piso_frame_transmitter_pkg.sv
// Shared definitions for the serial transmit blocks.
//   tx_state_t  : frame FSM state encoding (IDLE, START, DATA, STOP)
//   clog2_min1  : ceiling log2 that never returns less than 1, so a counter
//                 sized from a parameter always has at least one bit
package piso_frame_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_frame_transmitter_bit_timer.sv
// Bit-period timer for the frame transmitter.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   run     : count while high; the count is held at 0 while low
//   bit_end : high in the last clock of each BIT_CYCLES-long bit period
module piso_frame_transmitter_bit_timer
  import piso_frame_transmitter_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int CW = clog2_min1(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (!run || cyc_cnt == LAST_CYC) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // With BIT_CYCLES=1 the count stays at 0, so every running clock is a bit end.
  assign bit_end = run && (cyc_cnt == LAST_CYC);

endmodule

// File: rtl/piso_frame_transmitter.sv
// Parallel-in/serial-out framed transmitter.
// Frame on TxOut: start bit (0), WIDTH data bits, stop bit (1); each bit is
// held for BIT_CYCLES clocks. The line idles high.
//   Clk       : clock, rising edge
//   Clr       : asynchronous active-high reset
//   Din       : word to transmit, captured on accept
//   LoadValid : producer offers Din
//   LoadReady : transmitter can accept (high only in IDLE)
//   TxOut     : serial line
//   TxActive  : high while a frame is in progress
//   Done      : one-cycle pulse in the first IDLE cycle after the stop bit
module piso_frame_transmitter
  import piso_frame_transmitter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Din,
  input  logic             LoadValid,
  output logic             LoadReady,
  output logic             TxOut,
  output logic             TxActive,
  output logic             Done
);

  localparam int IW = clog2_min1(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [IW-1:0]    bit_idx;
  logic             bit_end;
  logic             accept;

  // The bit that goes on the line next always sits at the outgoing end of sreg.
  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  assign accept    = LoadValid && LoadReady;
  assign sreg_next = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);

  // TxActive is exactly "state != IDLE", so it doubles as the timer enable;
  // the timer is therefore parked at 0 whenever a frame is accepted.
  piso_frame_transmitter_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk     (Clk),
    .rst     (Clr),
    .run     (TxActive),
    .bit_end (bit_end)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      bit_idx   <= '0;
      TxOut     <= 1'b1;
      LoadReady <= 1'b1;
      TxActive  <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sreg      <= Din;
            bit_idx   <= '0;
            state     <= ST_START;
            TxOut     <= 1'b0;
            LoadReady <= 1'b0;
            TxActive  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            TxOut <= lead_bit(sreg);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              state <= ST_STOP;
              TxOut <= 1'b1;
            end else begin
              // Registered output: present the post-shift lead bit now.
              sreg    <= sreg_next;
              bit_idx <= bit_idx + 1'b1;
              TxOut   <= lead_bit(sreg_next);
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state     <= ST_IDLE;
            TxOut     <= 1'b1;
            LoadReady <= 1'b1;
            TxActive  <= 1'b0;
            Done      <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_transmitter.sv
module tb_piso_frame_transmitter;

  logic       clk;
  logic       clr;

  logic [7:0] din_a;
  logic       valid_a, ready_a, tx_a, act_a, done_a;
  logic [7:0] din_b;
  logic       valid_b, ready_b, tx_b, act_b, done_b;

  int compared;
  int mismatched;

  logic [0:9] seqv;

  // a: WIDTH=8, BIT_CYCLES=2, LSB first
  piso_frame_transmitter #(.WIDTH(8), .BIT_CYCLES(2), .LSB_FIRST(1)) u_a (
    .Clk(clk), .Clr(clr), .Din(din_a), .LoadValid(valid_a),
    .LoadReady(ready_a), .TxOut(tx_a), .TxActive(act_a), .Done(done_a)
  );

  // b: WIDTH=8, BIT_CYCLES=1, MSB first
  piso_frame_transmitter #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(0)) u_b (
    .Clk(clk), .Clr(clr), .Din(din_b), .LoadValid(valid_b),
    .LoadReady(ready_b), .TxOut(tx_b), .TxActive(act_b), .Done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clr = 1'b1;
    din_a = 8'h00; valid_a = 1'b0;
    din_b = 8'h00; valid_b = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    tick();

    // Reset state
    check("rst_tx_a",    tx_a,    1);
    check("rst_ready_a", ready_a, 1);
    check("rst_act_a",   act_a,   0);
    check("rst_done_a",  done_a,  0);
    check("rst_tx_b",    tx_b,    1);
    check("rst_ready_b", ready_b, 1);

    // 0xA5, 2 clocks per bit, LSB first
    seqv = 10'b0101001011;
    din_a = 8'hA5; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("a5_tx_%0d", i),    tx_a,    seqv[i/2]);
      check($sformatf("a5_act_%0d", i),   act_a,   1);
      check($sformatf("a5_done_%0d", i),  done_a,  0);
      check($sformatf("a5_ready_%0d", i), ready_a, 0);
      tick();
    end
    check("a5_done_pulse", done_a,  1);
    check("a5_done_ready", ready_a, 1);
    check("a5_done_act",   act_a,   0);
    check("a5_done_tx",    tx_a,    1);
    tick();
    check("a5_done_clear", done_a,  0);

    // 0x81, 1 clock per bit, MSB first
    seqv = 10'b0100000011;
    din_b = 8'h81; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("81_tx_%0d", i),   tx_b,   seqv[i]);
      check($sformatf("81_act_%0d", i),  act_b,  1);
      check($sformatf("81_done_%0d", i), done_b, 0);
      tick();
    end
    check("81_done_pulse", done_b, 1);
    check("81_act_low",    act_b,  0);
    tick();

    // Back-to-back: 0x3C then 0xC3 with LoadValid held high
    seqv = 10'b0001111001;
    din_b = 8'h3C; valid_b = 1'b1;
    tick();
    din_b = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("3c_tx_%0d", i),    tx_b,    seqv[i]);
      check($sformatf("3c_ready_%0d", i), ready_b, 0);
      tick();
    end
    check("b2b_done_pulse", done_b,  1);
    check("b2b_done_ready", ready_b, 1);
    check("b2b_idle_tx",    tx_b,    1);
    tick();
    valid_b = 1'b0;
    seqv = 10'b0110000111;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("c3_tx_%0d", i),  tx_b,  seqv[i]);
      check($sformatf("c3_act_%0d", i), act_b, 1);
      tick();
    end
    check("c3_done_pulse", done_b, 1);
    tick();
    check("c3_stay_idle", act_b, 0);

    // 0x96 on a, with 0xFF offered mid-DATA (must be ignored)
    seqv = 10'b0011010011;
    din_a = 8'h96; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) begin din_a = 8'hFF; valid_a = 1'b1; end
      if (i == 9) valid_a = 1'b0;
      check($sformatf("96_tx_%0d", i),    tx_a,    seqv[i/2]);
      check($sformatf("96_ready_%0d", i), ready_a, 0);
      tick();
    end
    check("96_done_pulse", done_a, 1);
    tick();
    check("96_no_reaccept", act_a, 0);

    // 0x5A on b with Din toggling every clock after accept
    seqv = 10'b0010110101;
    din_b = 8'h5A; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din_b = ~din_b;
      check($sformatf("5a_tx_%0d", i), tx_b, seqv[i]);
      tick();
    end
    check("5a_done_pulse", done_b, 1);
    tick();

    // Reset in the middle of DATA on a (0x00 keeps the line low)
    din_a = 8'h00; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_tx_low", tx_a,  0);
    check("mid_act",    act_a, 1);
    clr = 1'b1;
    #1;
    check("clr_async_tx",    tx_a,    1);
    check("clr_async_ready", ready_a, 1);
    check("clr_async_act",   act_a,   0);
    check("clr_async_done",  done_a,  0);
    #1;
    clr = 1'b0;
    tick();
    check("post_clr_tx",    tx_a,    1);
    check("post_clr_ready", ready_a, 1);
    check("post_clr_act",   act_a,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
